// File: rtl/demux8_reg.sv
// Registered 1-to-8 demux with per-channel hold registers and valid/ack.
// Optional broadcast write enabled by DEMUX8_BCAST_EN.
module demux8_reg #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
`ifdef DEMUX8_BCAST_EN
  input  logic               bcast,
`endif
  output logic [8*WIDTH-1:0] out_data,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ack,
  output logic [3:0]         occupancy
);

  logic [7:0]            valid_q, valid_d;
  logic [7:0][WIDTH-1:0] data_q, data_d;
  logic [3:0]            occ_q, occ_d;
  logic [7:0]            free;
  logic [7:0]            load;
  logic                  bc;
  logic                  acc;

`ifdef DEMUX8_BCAST_EN
  assign bc = bcast;
`else
  assign bc = 1'b0;
`endif

  // A slot can take a word if empty or being drained this cycle.
  assign free = ~valid_q | out_ack;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (bc) in_ready = &free;
      else    in_ready = free[in_sel];
    end
  end

  assign acc = in_valid & in_ready;

  always_comb begin
    load = 8'h00;
    if (acc) begin
      if (bc) load = 8'hFF;
      else    load = 8'h01 << in_sel;
    end
  end

  always_comb begin
    valid_d = (valid_q & ~out_ack) | load;
    data_d  = data_q;
    for (int k = 0; k < 8; k++) begin
      if (load[k]) data_d[k] = in_data;
    end
    if (reset) begin
      valid_d = 8'h00;
      data_d  = '0;
    end
  end

  always_comb begin
    occ_d = 4'd0;
    for (int k = 0; k < 8; k++) begin
      occ_d = occ_d + {3'd0, valid_d[k]};
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
    occ_q   <= occ_d;
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_demux8_reg.sv
// Self-checking bench for demux8_reg against a per-channel
// buffer model; covers unicast, pass-through, reset and broadcast.
module tb_demux8_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [7:0]  in_data;
  logic        bcast;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  bit         mv[8];
  logic [7:0] md[8];

`ifdef DEMUX8_BCAST_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  demux8_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
`ifdef DEMUX8_BCAST_EN
    .bcast     (bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occupancy (occupancy)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit slot_free(int k);
    return !mv[k] || out_ack[k];
  endfunction

  function automatic bit model_ready();
    bit all_free;
    if (reset) return 1'b0;
    if (BC_EN && bcast) begin
      all_free = 1'b1;
      for (int k = 0; k < 8; k++)
        if (!slot_free(k)) all_free = 1'b0;
      return all_free;
    end
    return slot_free(int'(in_sel));
  endfunction

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mv[k];
    return v;
  endfunction

  function automatic logic [63:0] model_data();
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = md[k];
    return d;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int k = 0; k < 8; k++) n += mv[k];
    return n;
  endfunction

  task automatic cycle(input bit r, input bit v,
                       input logic [2:0] s, input logic [7:0] d,
                       input logic [7:0] a, input bit b);
    bit rdy;
    reset    = r;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    out_ack  = a;
    bcast    = b;
    #1;
    rdy = model_ready();
    check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 8; k++) begin
        mv[k] = 1'b0;
        md[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 8; k++)
        if (a[k]) mv[k] = 1'b0;
      if (v && rdy) begin
        if (BC_EN && b) begin
          for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b1;
            md[k] = d;
          end
        end else begin
          mv[s] = 1'b1;
          md[s] = d;
        end
      end
    end
    #1;
    check("out_valid", {56'd0, out_valid}, {56'd0, model_valid()});
    check("occupancy", {60'd0, occupancy}, 64'(model_count()));
    check("out_data", out_data, model_data());
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      mv[k] = 1'b0;
      md[k] = 8'h00;
    end
    reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0;
    in_data = 8'h00; out_ack = 8'h00; bcast = 1'b0;

    cycle(1, 0, 3'd0, 8'h00, 8'h00, 0);
    cycle(1, 1, 3'd2, 8'h99, 8'h00, 0);
    check("rst_valid", {56'd0, out_valid}, 64'h00);
    check("rst_data", out_data, 64'h0);

    cycle(0, 1, 3'd3, 8'hA5, 8'h00, 0);
    check("fill_valid", {56'd0, out_valid}, 64'h08);
    check("fill_data3", {56'd0, out_data[31:24]}, 64'hA5);

    cycle(0, 1, 3'd3, 8'h77, 8'h00, 0);
    check("hold_data3", {56'd0, out_data[31:24]}, 64'hA5);

    cycle(0, 1, 3'd3, 8'h5A, 8'h08, 0);
    check("pass_data3", {56'd0, out_data[31:24]}, 64'h5A);
    check("pass_occ", {60'd0, occupancy}, 64'd1);

    for (int k = 0; k < 8; k++)
      cycle(0, 1, 3'(k), 8'(k + 1), 8'h01 << k, 0);
    check("full_valid", {56'd0, out_valid}, 64'hFF);

    cycle(0, 1, 3'd0, 8'hFF, 8'h85, 0);
    check("multi_valid", {56'd0, out_valid}, 64'h7B);
    check("multi_occ", {60'd0, occupancy}, 64'd6);
    check("multi_data0", {56'd0, out_data[7:0]}, 64'hFF);

    cycle(1, 1, 3'd4, 8'hEE, 8'h00, 0);
    check("mid_rst_valid", {56'd0, out_valid}, 64'h00);
    check("mid_rst_occ", {60'd0, occupancy}, 64'd0);

    if (BC_EN) begin
      cycle(0, 1, 3'd1, 8'h11, 8'h00, 0);
      cycle(0, 1, 3'd0, 8'h3C, 8'h00, 1);
      check("bc_blocked", {63'd0, in_ready}, 64'd0);
      cycle(0, 1, 3'd0, 8'h3C, 8'h02, 1);
      check("bc_valid", {56'd0, out_valid}, 64'hFF);
      check("bc_data", out_data, {8{8'h3C}});
      check("bc_occ", {60'd0, occupancy}, 64'd8);
    end

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            8'($urandom),
            8'($urandom) & 8'($urandom),
            ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
